// File: rtl/tail_light_pkg.sv
// Shared mode codes and lamp patterns for the tail-light sequencer and the
// state machine that feeds it.
package tail_light_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE   = 3'd0,
        MODE_HAZARD = 3'd1,
        MODE_LEFT   = 3'd2,
        MODE_RIGHT  = 3'd3
    } mode_e;

    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2,
        PH_3 = 2'd3
    } phase_e;

    localparam logic [2:0] PAT_OFF = 3'b000;
    localparam logic [2:0] PAT_1   = 3'b001;
    localparam logic [2:0] PAT_2   = 3'b011;
    localparam logic [2:0] PAT_3   = 3'b111;

    // Unused codes 4..7 fall back to idle.
    function automatic mode_e decode_mode(input logic [2:0] code);
        case (code)
            3'd1:    return MODE_HAZARD;
            3'd2:    return MODE_LEFT;
            3'd3:    return MODE_RIGHT;
            default: return MODE_IDLE;
        endcase
    endfunction

    // Sequential turn-signal fill, inner lamp first.
    function automatic logic [2:0] sweep_pat(input phase_e ph);
        case (ph)
            PH_1:    return PAT_1;
            PH_2:    return PAT_2;
            PH_3:    return PAT_3;
            default: return PAT_OFF;
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: one-cycle tick every TICK_DIV enabled clocks.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 25,
    parameter int unsigned DIV_W    = 5
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div;

    // Divider counter: restarts on clear or while disabled, wraps at DIV_LAST.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div <= '0;
        end else if (clr || !en) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign tick = en && (div == DIV_LAST);

endmodule

// File: rtl/tail_light_sequencer.sv
// Thunderbird-style tail-light sequencer: registers the mode code, steps a
// pattern phase at the prescaled rate and decodes six lamp outputs.
module tail_light_sequencer
    import tail_light_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25,
    parameter int unsigned DIV_W    = 5
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] CurrentState,
    output logic [2:0] LEDS_L,
    output logic [2:0] LEDS_R,
    output logic [1:0] PHASE
);

    logic [2:0] cmd_q;
    phase_e     phase_q;
    phase_e     phase_d;
    mode_e      mode;
    logic       mode_change;
    logic       tick;

    assign mode        = decode_mode(cmd_q);
    assign mode_change = (CurrentState != cmd_q);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (mode_change),
        .en    (mode != MODE_IDLE),
        .tick  (tick)
    );

    // State register: raw mode code and pattern phase.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cmd_q   <= '0;
            phase_q <= PH_0;
        end else begin
            cmd_q   <= CurrentState;
            phase_q <= phase_d;
        end
    end

    // Next phase: a mode change restarts the pattern even on a tick edge.
    always_comb begin
        phase_d = phase_q;
        if (mode_change) begin
            phase_d = PH_0;
        end else begin
            case (mode)
                MODE_HAZARD: if (tick) phase_d = (phase_q == PH_0) ? PH_1 : PH_0;
                MODE_LEFT,
                MODE_RIGHT:  if (tick) phase_d = phase_e'(phase_q + 2'd1);
                default:     phase_d = PH_0;
            endcase
        end
    end

    // Lamp decode from registered state only.
    always_comb begin
        LEDS_L = PAT_OFF;
        LEDS_R = PAT_OFF;
        case (mode)
            MODE_HAZARD: begin
                if (phase_q == PH_1) begin
                    LEDS_L = PAT_3;
                    LEDS_R = PAT_3;
                end
            end
            MODE_LEFT:  LEDS_L = sweep_pat(phase_q);
            MODE_RIGHT: LEDS_R = sweep_pat(phase_q);
            default: ;
        endcase
    end

    assign PHASE = phase_q;

endmodule
